// File: rtl/rx_frame_dispatch_fsm.sv
// rx_frame_dispatch_fsm: after a CRC-good receive, loads the header, filters by ID window and type, then dispatches one read enable.
// Latency: rx_done -> load_rd_en 1 cycle; got_frame -> ack/pass/usr_rd_en SN_WAIT+1 cycles.
// Backpressure: none; rx_done outside IDLE is ignored, and header waits are bounded by HDR_TMO.
module rx_frame_dispatch_fsm #(
    parameter int                ID_W      = 8,
    parameter int                TYPE_W    = 8,
    parameter logic [TYPE_W-1:0] ACK_TYPE  = 8'h32,
    parameter logic [TYPE_W-1:0] PASS_TYPE = 8'h51,
    parameter logic [TYPE_W-1:0] USR_TYPE  = 8'h00,
    parameter bit                USR_EN    = 1'b0,
    parameter int                SN_WAIT   = 3,
    parameter int                HDR_TMO   = 15,
    parameter int                CNT_W     = 16
) (
    input  logic              sys_clk,
    input  logic              glbl_rst,
    input  logic              init_done,
    input  logic              rx_done,
    input  logic              rx_crc_rslt,
    output logic              load_rd_en,
    input  logic              got_frame,
    input  logic [ID_W-1:0]   frame_id,
    input  logic [TYPE_W-1:0] frame_type,
    input  logic              sn_error,
    input  logic [1:0]        win_mode,
    input  logic [ID_W-1:0]   win0_min,
    input  logic [ID_W-1:0]   win0_max,
    input  logic [ID_W-1:0]   win1_min,
    input  logic [ID_W-1:0]   win1_max,
    output logic              ack_rd_en,
    output logic              pass_rd_en,
    output logic              usr_rd_en,
    output logic              busy,
    output logic [CNT_W-1:0]  crc_drop_cnt,
    output logic [CNT_W-1:0]  id_drop_cnt,
    output logic [CNT_W-1:0]  type_drop_cnt,
    output logic [CNT_W-1:0]  sn_drop_cnt,
    output logic [CNT_W-1:0]  tmo_cnt
);

    // Last cycle index of the header wait and of the SN-check window.
    localparam logic [7:0] HDR_LAST = 8'(HDR_TMO - 1);
    localparam logic [3:0] SN_LAST  = 4'(SN_WAIT - 1);

    localparam logic [1:0] CH_ACK  = 2'd0;
    localparam logic [1:0] CH_PASS = 2'd1;
    localparam logic [1:0] CH_USR  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // 3-bit encoding leaves spare codes; any of them falls back to IDLE.
    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_IDLE     = 3'd1,
        S_WAIT_HDR = 3'd2,
        S_SN_CHK   = 3'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [7:0]         r_hdr_cnt, w_hdr_cnt_nxt;
    logic [3:0]         r_sn_cnt, w_sn_cnt_nxt;
    logic [1:0]         r_chan, w_chan_nxt;

    logic               r_load, w_load_nxt;
    logic               r_ack, w_ack_nxt;
    logic               r_pass, w_pass_nxt;
    logic               r_usr, w_usr_nxt;

    logic               w_latch;
    logic [1:0]         r_win_mode;
    logic [ID_W-1:0]    r_w0_min, r_w0_max, r_w1_min, r_w1_max;

    logic               w_inc_crc, w_inc_id, w_inc_type, w_inc_sn, w_inc_tmo;
    logic [CNT_W-1:0]   r_crc_cnt, r_id_cnt, r_type_cnt, r_sn_cnt_d, r_tmo_cnt;

    logic               w_in_w0, w_in_w1, w_id_match;
    logic               w_type_ok;
    logic [1:0]         w_type_chan;

    // An inverted window (min > max) naturally fails both compares.
    assign w_in_w0 = (r_w0_min <= frame_id) && (frame_id <= r_w0_max);
    assign w_in_w1 = (r_w1_min <= frame_id) && (frame_id <= r_w1_max);

    // ID window match against the configuration latched at init.
    always_comb begin
        w_id_match = 1'b0;
        case (r_win_mode)
            2'd0:    w_id_match = w_in_w0;
            2'd1:    w_id_match = w_in_w0 | w_in_w1;
            2'd2:    w_id_match = (frame_id == r_w0_min) || (frame_id == r_w0_max);
            default: w_id_match = 1'b1;
        endcase
    end

    // Type classification; colliding codes resolve ack > pass > user.
    always_comb begin
        w_type_ok   = 1'b1;
        w_type_chan = CH_ACK;
        if (frame_type == ACK_TYPE) begin
            w_type_chan = CH_ACK;
        end else if (frame_type == PASS_TYPE) begin
            w_type_chan = CH_PASS;
        end else if (USR_EN && (frame_type == USR_TYPE)) begin
            w_type_chan = CH_USR;
        end else begin
            w_type_ok = 1'b0;
        end
    end

    // Next-state, next-pulse and counter-increment decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_hdr_cnt_nxt = r_hdr_cnt;
        w_sn_cnt_nxt  = r_sn_cnt;
        w_chan_nxt    = r_chan;
        w_load_nxt    = 1'b0;
        w_ack_nxt     = 1'b0;
        w_pass_nxt    = 1'b0;
        w_usr_nxt     = 1'b0;
        w_latch       = 1'b0;
        w_inc_crc     = 1'b0;
        w_inc_id      = 1'b0;
        w_inc_type    = 1'b0;
        w_inc_sn      = 1'b0;
        w_inc_tmo     = 1'b0;
        case (r_state)
            S_INIT: begin
                if (init_done) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (rx_done) begin
                    if (rx_crc_rslt) begin
                        w_load_nxt    = 1'b1;
                        w_hdr_cnt_nxt = 8'd0;
                        w_state_nxt   = S_WAIT_HDR;
                    end else begin
                        w_inc_crc = 1'b1;
                    end
                end
            end
            S_WAIT_HDR: begin
                if (got_frame) begin
                    if (!w_id_match) begin
                        w_inc_id    = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (!w_type_ok) begin
                        w_inc_type  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_chan_nxt   = w_type_chan;
                        w_sn_cnt_nxt = 4'd0;
                        w_state_nxt  = S_SN_CHK;
                    end
                end else if (r_hdr_cnt == HDR_LAST) begin
                    w_inc_tmo   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hdr_cnt_nxt = r_hdr_cnt + 8'd1;
                end
            end
            S_SN_CHK: begin
                // An SN error, even on the final cycle, suppresses dispatch.
                if (sn_error) begin
                    w_inc_sn    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_sn_cnt == SN_LAST) begin
                    w_ack_nxt   = (r_chan == CH_ACK);
                    w_pass_nxt  = (r_chan == CH_PASS);
                    w_usr_nxt   = (r_chan == CH_USR);
                    w_state_nxt = S_IDLE;
                end else begin
                    w_sn_cnt_nxt = r_sn_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Cycle counters, registered channel, output pulses and window latch.
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            r_hdr_cnt  <= 8'd0;
            r_sn_cnt   <= 4'd0;
            r_chan     <= CH_ACK;
            r_load     <= 1'b0;
            r_ack      <= 1'b0;
            r_pass     <= 1'b0;
            r_usr      <= 1'b0;
            r_win_mode <= 2'd0;
            r_w0_min   <= '0;
            r_w0_max   <= '0;
            r_w1_min   <= '0;
            r_w1_max   <= '0;
        end else begin
            r_hdr_cnt <= w_hdr_cnt_nxt;
            r_sn_cnt  <= w_sn_cnt_nxt;
            r_chan    <= w_chan_nxt;
            r_load    <= w_load_nxt;
            r_ack     <= w_ack_nxt;
            r_pass    <= w_pass_nxt;
            r_usr     <= w_usr_nxt;
            if (w_latch) begin
                r_win_mode <= win_mode;
                r_w0_min   <= win0_min;
                r_w0_max   <= win0_max;
                r_w1_min   <= win1_min;
                r_w1_max   <= win1_max;
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    // Saturating drop and diagnostic counters.
    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            r_crc_cnt  <= '0;
            r_id_cnt   <= '0;
            r_type_cnt <= '0;
            r_sn_cnt_d <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            if (w_inc_crc)  r_crc_cnt  <= sat_inc(r_crc_cnt);
            if (w_inc_id)   r_id_cnt   <= sat_inc(r_id_cnt);
            if (w_inc_type) r_type_cnt <= sat_inc(r_type_cnt);
            if (w_inc_sn)   r_sn_cnt_d <= sat_inc(r_sn_cnt_d);
            if (w_inc_tmo)  r_tmo_cnt  <= sat_inc(r_tmo_cnt);
        end
    end

    assign load_rd_en    = r_load;
    assign ack_rd_en     = r_ack;
    assign pass_rd_en    = r_pass;
    assign usr_rd_en     = r_usr;
    assign busy          = (r_state != S_INIT) && (r_state != S_IDLE);
    assign crc_drop_cnt  = r_crc_cnt;
    assign id_drop_cnt   = r_id_cnt;
    assign type_drop_cnt = r_type_cnt;
    assign sn_drop_cnt   = r_sn_cnt_d;
    assign tmo_cnt       = r_tmo_cnt;

endmodule

// File: tb/tb_rx_frame_dispatch_fsm.sv
// Bench for rx_frame_dispatch_fsm: directed scenarios plus randomized frames against a rule-level outcome model.
// A second instance (user channel enabled, 2-bit counters) shares all inputs.
// Each frame runs a fixed window of NCYC cycles, so no wait can hang.
module tb_rx_frame_dispatch_fsm;

    localparam int SN_WAIT = 3;
    localparam int HDR_TMO = 15;
    localparam int NCYC    = 32;

    logic       sys_clk = 1'b0;
    logic       glbl_rst, init_done, rx_done, rx_crc_rslt, got_frame, sn_error;
    logic [7:0] frame_id, frame_type, win0_min, win0_max, win1_min, win1_max;
    logic [1:0] win_mode;

    logic        d_load, d_ack, d_pass, d_usr, d_busy;
    logic [15:0] d_crc, d_id, d_type, d_sn, d_tmo;
    logic        u_load, u_ack, u_pass, u_usr, u_busy;
    logic [1:0]  u_crc, u_id, u_type, u_sn, u_tmo;

    int errors = 0;
    int checks = 0;
    int exp_crc, exp_id, exp_type, exp_sn, exp_tmo;

    // observations of the last run_frame
    int   ob_load_n, ob_load_cyc, ob_ack_n, ob_pass_n, ob_usr_n, ob_pulse_cyc, ob_u_usr_n, ob_u_pulse_cyc;
    logic ob_busy [0:NCYC];

    always #5 sys_clk = ~sys_clk;

    rx_frame_dispatch_fsm #(.SN_WAIT(SN_WAIT), .HDR_TMO(HDR_TMO)) dut (
        .sys_clk(sys_clk), .glbl_rst(glbl_rst), .init_done(init_done), .rx_done(rx_done),
        .rx_crc_rslt(rx_crc_rslt), .load_rd_en(d_load), .got_frame(got_frame), .frame_id(frame_id),
        .frame_type(frame_type), .sn_error(sn_error), .win_mode(win_mode), .win0_min(win0_min),
        .win0_max(win0_max), .win1_min(win1_min), .win1_max(win1_max), .ack_rd_en(d_ack),
        .pass_rd_en(d_pass), .usr_rd_en(d_usr), .busy(d_busy), .crc_drop_cnt(d_crc),
        .id_drop_cnt(d_id), .type_drop_cnt(d_type), .sn_drop_cnt(d_sn), .tmo_cnt(d_tmo));

    rx_frame_dispatch_fsm #(.SN_WAIT(SN_WAIT), .HDR_TMO(HDR_TMO), .USR_EN(1'b1), .CNT_W(2)) dut_u (
        .sys_clk(sys_clk), .glbl_rst(glbl_rst), .init_done(init_done), .rx_done(rx_done),
        .rx_crc_rslt(rx_crc_rslt), .load_rd_en(u_load), .got_frame(got_frame), .frame_id(frame_id),
        .frame_type(frame_type), .sn_error(sn_error), .win_mode(win_mode), .win0_min(win0_min),
        .win0_max(win0_max), .win1_min(win1_min), .win1_max(win1_max), .ack_rd_en(u_ack),
        .pass_rd_en(u_pass), .usr_rd_en(u_usr), .busy(u_busy), .crc_drop_cnt(u_crc),
        .id_drop_cnt(u_id), .type_drop_cnt(u_type), .sn_drop_cnt(u_sn), .tmo_cnt(u_tmo));

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Outcome of one accepted-CRC frame from the behavioural rules.
    // 0 timeout, 1 id drop, 2 type drop, 3 sn drop, 4 ack, 5 pass, 6 user.
    function automatic int model_outcome(input int mode, input int a0, input int b0, input int a1,
                                         input int b1, input int id, input int typ, input bit usr_en,
                                         input int gcyc, input int sncyc);
        bit hit;
        int ch;
        if (gcyc == 0 || gcyc > HDR_TMO) return 0;
        case (mode)
            0:       hit = (id >= a0 && id <= b0);
            1:       hit = (id >= a0 && id <= b0) || (id >= a1 && id <= b1);
            2:       hit = (id == a0) || (id == b0);
            default: hit = 1'b1;
        endcase
        if (!hit) return 1;
        if (typ == 'h32) ch = 4;
        else if (typ == 'h51) ch = 5;
        else if (usr_en && typ == 'h00) ch = 6;
        else return 2;
        if (sncyc > gcyc && sncyc <= gcyc + SN_WAIT) return 3;
        return ch;
    endfunction

    task automatic idle_inputs();
        rx_done = 1'b0; rx_crc_rslt = 1'b0; got_frame = 1'b0; sn_error = 1'b0;
    endtask

    task automatic do_init(input int mode, input int a0, input int b0, input int a1, input int b1);
        idle_inputs();
        glbl_rst = 1'b1; init_done = 1'b0;
        tick(); tick();
        glbl_rst = 1'b0;
        win_mode = 2'(mode); win0_min = 8'(a0); win0_max = 8'(b0); win1_min = 8'(a1); win1_max = 8'(b1);
        init_done = 1'b1;
        tick();
        exp_crc = 0; exp_id = 0; exp_type = 0; exp_sn = 0; exp_tmo = 0;
    endtask

    // Drives one receive; cycle 0 carries rx_done, later events at the given cycle numbers (0 = none).
    task automatic run_frame(input int id, input int typ, input int gcyc, input int sncyc,
                             input int noisecyc, input bit crc_ok);
        ob_load_n = 0; ob_ack_n = 0; ob_pass_n = 0; ob_usr_n = 0; ob_u_usr_n = 0;
        ob_load_cyc = -1; ob_pulse_cyc = -1; ob_u_pulse_cyc = -1;
        ob_busy[0] = d_busy;
        frame_id = 8'(id); frame_type = 8'(typ);
        for (int c = 0; c < NCYC; c++) begin
            rx_done     = (c == 0) || (noisecyc != 0 && c == noisecyc);
            rx_crc_rslt = (c == 0) ? crc_ok : 1'b0;
            got_frame   = (gcyc != 0 && c == gcyc);
            sn_error    = (sncyc != 0 && c == sncyc);
            tick();
            if (d_load) begin ob_load_n++; if (ob_load_cyc < 0) ob_load_cyc = c + 1; end
            if (d_ack) ob_ack_n++;
            if (d_pass) ob_pass_n++;
            if (d_usr) ob_usr_n++;
            if ((d_ack || d_pass || d_usr) && ob_pulse_cyc < 0) ob_pulse_cyc = c + 1;
            if (u_usr) ob_u_usr_n++;
            if ((u_ack || u_pass || u_usr) && ob_u_pulse_cyc < 0) ob_u_pulse_cyc = c + 1;
            ob_busy[c + 1] = d_busy;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        init_done = 1'b0; win_mode = 2'd0;
        win0_min = 8'd0; win0_max = 8'd0; win1_min = 8'd0; win1_max = 8'd0;
        frame_id = 8'd0; frame_type = 8'd0;
        glbl_rst = 1'b1;
        tick(); tick();
        checks++; if ({d_load, d_ack, d_pass, d_usr, d_busy} !== 5'b0) begin errors++; $display("FAIL reset_pulses: got %b want 00000", {d_load, d_ack, d_pass, d_usr, d_busy}); end
        checks++; if ({d_crc, d_id, d_type, d_sn, d_tmo} !== 80'd0) begin errors++; $display("FAIL reset_counters: got %h want 0", {d_crc, d_id, d_type, d_sn, d_tmo}); end
        glbl_rst = 1'b0;
    endtask

    task automatic test_no_init();
        run_frame(30, 'h32, 2, 0, 0, 1'b1);
        run_frame(30, 'h32, 0, 0, 0, 1'b0);
        checks++; if (ob_load_n !== 0) begin errors++; $display("FAIL noinit_load: got %0d want 0", ob_load_n); end
        checks++; if (d_crc !== 16'd0 || d_busy !== 1'b0) begin errors++; $display("FAIL noinit_crc_busy: got crc=%0d busy=%b want 0/0", d_crc, d_busy); end
    endtask

    task automatic test_mode0_ack();
        do_init(0, 24, 71, 0, 0);
        run_frame(71, 'h32, 1, 0, 0, 1'b1);
        checks++; if (ob_load_cyc !== 1 || ob_load_n !== 1) begin errors++; $display("FAIL m0_load: got cyc=%0d n=%0d want 1/1", ob_load_cyc, ob_load_n); end
        checks++; if (ob_ack_n !== 1 || ob_pass_n + ob_usr_n !== 0) begin errors++; $display("FAIL m0_ack_n: got ack=%0d other=%0d want 1/0", ob_ack_n, ob_pass_n + ob_usr_n); end
        checks++; if (ob_pulse_cyc !== 1 + SN_WAIT + 1) begin errors++; $display("FAIL m0_ack_cyc: got %0d want %0d", ob_pulse_cyc, 1 + SN_WAIT + 1); end
        checks++; if ({d_crc, d_id, d_type, d_sn, d_tmo} !== 80'd0) begin errors++; $display("FAIL m0_counters: got %h want 0", {d_crc, d_id, d_type, d_sn, d_tmo}); end
    endtask

    task automatic test_mode1();
        do_init(1, 0, 5, 24, 29);
        run_frame(27, 'h51, 2, 0, 0, 1'b1);
        checks++; if (ob_pass_n !== 1 || ob_pulse_cyc !== 2 + SN_WAIT + 1) begin errors++; $display("FAIL m1_pass: got n=%0d cyc=%0d want 1/%0d", ob_pass_n, ob_pulse_cyc, 2 + SN_WAIT + 1); end
        run_frame(12, 'h51, 2, 0, 0, 1'b1);
        checks++; if (ob_pulse_cyc !== -1 || d_id !== 16'd1) begin errors++; $display("FAIL m1_id_drop: got pulse=%0d id_cnt=%0d want -1/1", ob_pulse_cyc, d_id); end
    endtask

    task automatic test_mode2_type();
        do_init(2, 6, 18, 0, 0);
        run_frame(6, 'h32, 1, 0, 0, 1'b1);
        checks++; if (ob_ack_n !== 1) begin errors++; $display("FAIL m2_exact_min: got ack=%0d want 1", ob_ack_n); end
        run_frame(7, 'h32, 1, 0, 0, 1'b1);
        checks++; if (ob_pulse_cyc !== -1 || d_id !== 16'd1) begin errors++; $display("FAIL m2_between: got pulse=%0d id_cnt=%0d want -1/1", ob_pulse_cyc, d_id); end
        run_frame(18, 'h99, 1, 0, 0, 1'b1);
        checks++; if (ob_pulse_cyc !== -1 || d_type !== 16'd1) begin errors++; $display("FAIL m2_type_drop: got pulse=%0d type_cnt=%0d want -1/1", ob_pulse_cyc, d_type); end
        run_frame(6, 'h00, 1, 0, 0, 1'b1);
        checks++; if (d_type !== 16'd2 || ob_pulse_cyc !== -1) begin errors++; $display("FAIL usr_disabled: got type_cnt=%0d pulse=%0d want 2/-1", d_type, ob_pulse_cyc); end
        checks++; if (ob_u_usr_n !== 1 || ob_u_pulse_cyc !== 1 + SN_WAIT + 1) begin errors++; $display("FAIL usr_enabled: got n=%0d cyc=%0d want 1/%0d", ob_u_usr_n, ob_u_pulse_cyc, 1 + SN_WAIT + 1); end
    endtask

    task automatic test_sn_error();
        do_init(0, 24, 71, 0, 0);
        run_frame(40, 'h32, 1, 3, 0, 1'b1);
        checks++; if (ob_pulse_cyc !== -1 || d_sn !== 16'd1) begin errors++; $display("FAIL sn_mid: got pulse=%0d sn_cnt=%0d want -1/1", ob_pulse_cyc, d_sn); end
        checks++; if (ob_busy[3] !== 1'b1 || ob_busy[4] !== 1'b0) begin errors++; $display("FAIL sn_busy: got %b%b want 10", ob_busy[3], ob_busy[4]); end
        run_frame(40, 'h32, 1, 1 + SN_WAIT, 0, 1'b1);
        checks++; if (ob_pulse_cyc !== -1 || d_sn !== 16'd2) begin errors++; $display("FAIL sn_final: got pulse=%0d sn_cnt=%0d want -1/2", ob_pulse_cyc, d_sn); end
        run_frame(40, 'h32, 1, 2 + SN_WAIT, 0, 1'b1);
        checks++; if (ob_ack_n !== 1 || d_sn !== 16'd2) begin errors++; $display("FAIL sn_late: got ack=%0d sn_cnt=%0d want 1/2", ob_ack_n, d_sn); end
    endtask

    task automatic test_timeout_crc();
        do_init(0, 24, 71, 0, 0);
        run_frame(30, 'h32, 0, 0, 0, 1'b1);
        checks++; if (d_tmo !== 16'd1 || ob_pulse_cyc !== -1) begin errors++; $display("FAIL tmo_count: got tmo=%0d pulse=%0d want 1/-1", d_tmo, ob_pulse_cyc); end
        checks++; if (ob_busy[HDR_TMO] !== 1'b1 || ob_busy[HDR_TMO + 1] !== 1'b0) begin errors++; $display("FAIL tmo_edge: got %b%b want 10", ob_busy[HDR_TMO], ob_busy[HDR_TMO + 1]); end
        run_frame(30, 'h32, HDR_TMO, 0, 0, 1'b1);
        checks++; if (ob_ack_n !== 1 || d_tmo !== 16'd1) begin errors++; $display("FAIL tmo_last_cycle: got ack=%0d tmo=%0d want 1/1", ob_ack_n, d_tmo); end
        run_frame(30, 'h32, HDR_TMO + 1, 0, 0, 1'b1);
        checks++; if (ob_pulse_cyc !== -1 || d_tmo !== 16'd2) begin errors++; $display("FAIL tmo_too_late: got pulse=%0d tmo=%0d want -1/2", ob_pulse_cyc, d_tmo); end
        run_frame(30, 'h32, 1, 0, 0, 1'b0);
        checks++; if (ob_load_n !== 0 || d_crc !== 16'd1 || ob_busy[1] !== 1'b0) begin errors++; $display("FAIL crc_bad: got load=%0d crc=%0d busy=%b want 0/1/0", ob_load_n, d_crc, ob_busy[1]); end
    endtask

    task automatic test_busy_ignore();
        do_init(0, 24, 71, 0, 0);
        run_frame(30, 'h51, 2, 0, 1, 1'b1);
        run_frame(30, 'h51, 2, 0, 4, 1'b1);
        checks++; if (ob_pass_n !== 1 || ob_load_n !== 1 || d_crc !== 16'd0) begin errors++; $display("FAIL busy_rx_ignored: got pass=%0d load=%0d crc=%0d want 1/1/0", ob_pass_n, ob_load_n, d_crc); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_init(0, 24, 71, 0, 0);
        frame_id = 8'd30; frame_type = 8'h32;
        rx_done = 1'b1; rx_crc_rslt = 1'b1; tick();
        rx_done = 1'b0; rx_crc_rslt = 1'b0; got_frame = 1'b1; tick();
        got_frame = 1'b0; glbl_rst = 1'b1; tick();
        checks++; if ({d_load, d_ack, d_pass, d_usr, d_busy} !== 5'b0 || {d_crc, d_id, d_type, d_sn, d_tmo} !== 80'd0) begin errors++; $display("FAIL reset_mid_outputs: got %b %h want 0", {d_load, d_ack, d_pass, d_usr, d_busy}, {d_crc, d_id, d_type, d_sn, d_tmo}); end
        glbl_rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (d_ack || d_pass || d_usr) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL reset_mid_pulse: got %0d want 0", pulses); end
    endtask

    task automatic test_window_latched();
        do_init(0, 24, 71, 0, 0);
        win_mode = 2'd3; win0_min = 8'd0; win0_max = 8'd5;
        run_frame(30, 'h32, 1, 0, 0, 1'b1);
        checks++; if (ob_ack_n !== 1) begin errors++; $display("FAIL latch_old_hit: got ack=%0d want 1", ob_ack_n); end
        run_frame(3, 'h32, 1, 0, 0, 1'b1);
        checks++; if (ob_pulse_cyc !== -1 || d_id !== 16'd1) begin errors++; $display("FAIL latch_new_ignored: got pulse=%0d id_cnt=%0d want -1/1", ob_pulse_cyc, d_id); end
    endtask

    task automatic test_saturation();
        do_init(0, 24, 71, 0, 0);
        for (int i = 0; i < 5; i++) begin
            rx_done = 1'b1; rx_crc_rslt = 1'b0; tick();
            rx_done = 1'b0; tick();
        end
        checks++; if (u_crc !== 2'd3) begin errors++; $display("FAIL crc_saturate: got %0d want 3", u_crc); end
        checks++; if (d_crc !== 16'd5) begin errors++; $display("FAIL crc_wide: got %0d want 5", d_crc); end
    endtask

    task automatic test_random();
        int mode, a0, b0, a1, b1, t, id, typ, gcyc, sncyc, out, out_u;
        mode = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        for (int f = 0; f < 40; f++) begin
            if (f % 10 == 0) begin
                mode = $urandom_range(0, 3);
                a0 = $urandom_range(0, 255); b0 = $urandom_range(0, 255);
                a1 = $urandom_range(0, 255); b1 = $urandom_range(0, 255);
                if (mode == 2 || $urandom_range(0, 3) != 0) begin
                    if (a0 > b0) begin t = a0; a0 = b0; b0 = t; end
                    if (a1 > b1) begin t = a1; a1 = b1; b1 = t; end
                end
                do_init(mode, a0, b0, a1, b1);
            end
            case ($urandom_range(0, 4))
                0: id = a0;
                1: id = b0;
                2: id = a1;
                3: id = (a0 + b0) / 2;
                default: id = $urandom_range(0, 255);
            endcase
            case ($urandom_range(0, 3))
                0: typ = 'h32;
                1: typ = 'h51;
                2: typ = 'h00;
                default: typ = $urandom_range(0, 255);
            endcase
            gcyc  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            sncyc = ($urandom_range(0, 2) == 0) ? gcyc + $urandom_range(0, SN_WAIT + 1) : 0;
            out   = model_outcome(mode, a0, b0, a1, b1, id, typ, 1'b0, gcyc, sncyc);
            out_u = model_outcome(mode, a0, b0, a1, b1, id, typ, 1'b1, gcyc, sncyc);
            run_frame(id, typ, gcyc, sncyc, 0, 1'b1);
            if (out == 0) exp_tmo++;
            if (out == 1) exp_id++;
            if (out == 2) exp_type++;
            if (out == 3) exp_sn++;
            checks++; if (ob_load_n !== 1) begin errors++; $display("FAIL rnd_load f=%0d: got %0d want 1", f, ob_load_n); end
            checks++; if (ob_ack_n !== int'(out == 4) || ob_pass_n !== int'(out == 5) || ob_usr_n !== 0) begin errors++; $display("FAIL rnd_pulse f=%0d: got ack=%0d pass=%0d usr=%0d outcome=%0d", f, ob_ack_n, ob_pass_n, ob_usr_n, out); end
            checks++; if (ob_pulse_cyc !== ((out >= 4) ? gcyc + SN_WAIT + 1 : -1)) begin errors++; $display("FAIL rnd_pulse_cyc f=%0d: got %0d outcome=%0d g=%0d", f, ob_pulse_cyc, out, gcyc); end
            checks++; if (ob_u_usr_n !== int'(out_u == 6)) begin errors++; $display("FAIL rnd_usr f=%0d: got %0d want %0d", f, ob_u_usr_n, int'(out_u == 6)); end
            checks++; if (d_id !== 16'(exp_id) || d_type !== 16'(exp_type) || d_sn !== 16'(exp_sn) || d_tmo !== 16'(exp_tmo) || d_crc !== 16'(exp_crc)) begin errors++; $display("FAIL rnd_counters f=%0d: got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d", f, d_id, d_type, d_sn, d_tmo, d_crc, exp_id, exp_type, exp_sn, exp_tmo, exp_crc); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_crc = 0; exp_id = 0; exp_type = 0; exp_sn = 0; exp_tmo = 0;
        tick();
        test_reset();
        test_no_init();
        test_mode0_ack();
        test_mode1();
        test_mode2_type();
        test_sn_error();
        test_timeout_crc();
        test_busy_ignore();
        test_reset_mid();
        test_window_latched();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_frame_dispatch_fsm.md
Name: rx_frame_dispatch_fsm

Overview:
Parametrised receive-side dispatch controller for the T/L-bus frame path. After a CRC-good receive it requests a frame-buffer load and classifies the frame by ID window and type. It waits a programmable SN-check window, then pulses the matching read enable (ack, pass or user type). Unlike the fixed card-ID table design, the ID windows are supplied at run time, and the block adds a header timeout plus saturating drop/diagnostic counters.

Parameters:
ID_W, 8, frame_id and window bound width
TYPE_W, 8, frame_type width
ACK_TYPE, 8'h32, type code routed to ack_rd_en
PASS_TYPE, 8'h51, type code routed to pass_rd_en
USR_TYPE, 8'h00, extra type code routed to usr_rd_en; the channel is disabled when USR_EN=0
USR_EN, 0, enables the user channel
SN_WAIT, 3, cycles spent in SN_CHK before dispatch (1..15)
HDR_TMO, 15, max cycles in WAIT_HDR before abort (1..255)
CNT_W, 16, diagnostic counter width

Ports:
sys_clk  in  1  system clock
glbl_rst  in  1  synchronous reset, active-high
init_done  in  1  configuration valid; level
rx_done  in  1  1-cycle pulse, receive complete
rx_crc_rslt  in  1  CRC good, qualified by rx_done
load_rd_en  out  1  1-cycle pulse, load frame header
got_frame  in  1  header fields valid
frame_id  in  ID_W  received frame ID
frame_type  in  TYPE_W  received frame type
sn_error  in  1  sequence-number error from SN checker
win_mode  in  2  0=single range W0; 1=W0 or W1 range; 2=exact match W0.min or W0.max; 3=accept all
win0_min / win0_max  in  ID_W each  window 0 bounds (inclusive)
win1_min / win1_max  in  ID_W each  window 1 bounds (inclusive)
ack_rd_en / pass_rd_en / usr_rd_en  out  1 each  1-cycle dispatch pulses
busy  out  1  high in any state other than INIT and IDLE
crc_drop_cnt / id_drop_cnt / type_drop_cnt / sn_drop_cnt / tmo_cnt  out  CNT_W each  saturating counters

Behaviour:
- Reset values: all outputs 0, all counters 0, state INIT, latched window registers 0. Reset wins over every other event; reset mid-frame returns to INIT with no dispatch pulse.
- INIT: waits for init_done=1. On that cycle it latches win_mode and all four bounds, then goes to IDLE. The latched values are used until the next reset; later port changes are ignored.
- IDLE: on rx_done&rx_crc_rslt, pulse load_rd_en for exactly 1 cycle and go to WAIT_HDR. On rx_done&!rx_crc_rslt, crc_drop_cnt+1 and stay in IDLE. rx_done outside IDLE is ignored and not counted.
- WAIT_HDR: a cycle counter starts at 0.
  - On got_frame=1: evaluate the window match.
    - No window match: id_drop_cnt+1, go to IDLE.
    - Window match but type matches no enabled code: type_drop_cnt+1, go to IDLE.
    - Window and type match: register the type channel and go to SN_CHK.
  - If got_frame stays 0 for HDR_TMO cycles: tmo_cnt+1, go to IDLE.
- Window match rules:
  - Compare unsigned and inclusive.
  - Mode 1 matches when the ID is in W0 or in W1.
  - An inverted window (min>max) matches nothing.
  - Mode 3 always matches.
- SN_CHK: count cycles from 0.
  - sn_error=1 on any cycle: sn_drop_cnt+1, go to IDLE, no dispatch.
  - When the count reaches SN_WAIT-1 with no error: pulse the registered channel's rd_en for 1 cycle, go to IDLE.
  - sn_error on that same final cycle takes priority: drop, no pulse.
- Latency: rx_done to load_rd_en is 1 cycle. got_frame to rd_en pulse is SN_WAIT+1 cycles.
- At most one rd_en pulse per accepted frame. The three rd_en outputs are mutually exclusive.
- Counters saturate at all-ones and never wrap.
- Illegal state encoding recovers to IDLE on the next cycle.

Test Plan:
- Mode 0, W0=24..71, rx_done+crc good, got_frame with id=71, type=8'h32, SN_WAIT=3 -> load_rd_en pulse 1 cycle after rx_done; ack_rd_en single pulse 4 cycles after got_frame; all counters stay 0.
- Mode 1, W0=0..5, W1=24..29: id=27 with type 8'h51 -> pass_rd_en pulse; id=12 -> no pulse and id_drop_cnt=1.
- Mode 2, W0=(6,18): id=6 accepted; id=7 dropped. Type 8'h99 with USR_EN=0 on an in-window ID -> type_drop_cnt=1.
- In-window ack frame with sn_error asserted on the 2nd SN_CHK cycle -> no rd_en pulse, sn_drop_cnt=1, busy low the next cycle.
- got_frame withheld after load_rd_en -> tmo_cnt=1 after HDR_TMO cycles; rx_done with crc=0 -> crc_drop_cnt=1, no load_rd_en.
- Reset asserted in SN_CHK -> no dispatch, all outputs 0. init_done low -> rx_done ignored. Window ports changed after init -> old window still applied. CNT_W=2 with 5 CRC errors -> crc_drop_cnt holds at 3.
